fifo_enq_arbiter: RTL

//  Round-robin arbiter sharing one FIFO enqueue port among NUM_REQ producers.

---
 rtl/fifo_enq_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin arbiter with bounded bursts feeding one FIFO enqueue port.
// Define FIFO_ARB_STATS_EN to add saturating per-requester beat counters on grant_cnt_o.
module fifo_enq_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       fifo_valid_o,
    output logic [DATA_W-1:0]          fifo_data_o,
    input  logic                       fifo_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] owner_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]   grant_cnt_o
`endif
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(MAX_BURST - 1);
    localparam logic [IDX_W:0]   NUM_REQ_W  = (IDX_W + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ - 1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IDX_W-1:0]  sel_s;
    logic              cand_valid_s;
    logic              beat_s;
    logic [DATA_W-1:0] word_s [NUM_REQ];

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        logic [IDX_W:0] sum;
        sum = {1'b0, idx} + (IDX_W + 1)'(1);
        return (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W) : sum[IDX_W-1:0];
    endfunction

    // Scanning from the far end lets the closest valid index to ptr win last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] pos;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            pos = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W) : sum[IDX_W-1:0];
            if (valid[pos]) begin
                pick = pos;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign word_s[g] = req_data_i[g*DATA_W +: DATA_W];
    end

    // Candidate selection: the locked owner, or the round-robin winner.
    always_comb begin
        if (state_q == LOCK) begin
            sel_s = owner_q;
        end else begin
            sel_s = rr_pick(req_valid_i, rr_ptr_q);
        end
    end

    assign cand_valid_s = req_valid_i[sel_s];
    assign beat_s       = cand_valid_s & fifo_ready_i;
    assign owner_o      = owner_q;

    // Zero-latency datapath; reset silences every handshake output.
    always_comb begin
        fifo_valid_o = 1'b0;
        fifo_data_o  = {DATA_W{1'b0}};
        req_ready_o  = {NUM_REQ{1'b0}};
        if (rst) begin
            fifo_valid_o = 1'b0;
        end else begin
            fifo_valid_o = cand_valid_s;
            fifo_data_o  = cand_valid_s ? word_s[sel_s] : {DATA_W{1'b0}};
            if ((state_q == LOCK) || cand_valid_s) begin
                req_ready_o = (ONE_HOT0 << sel_s) & {NUM_REQ{fifo_ready_i}};
            end else begin
                req_ready_o = {NUM_REQ{1'b0}};
            end
        end
    end

    // Next-state: burst accounting, stall lock and early release.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        if (beat_s) begin
            owner_d = sel_s;
            if (burst_cnt_q == BURST_LAST) begin
                state_d     = ARB;
                rr_ptr_d    = idx_inc(sel_s);
                burst_cnt_d = {BC_W{1'b0}};
            end else begin
                state_d     = LOCK;
                burst_cnt_d = burst_cnt_q + BC_W'(1);
            end
        end else if (cand_valid_s) begin
            // Stalled: pin the candidate so the offered word cannot change.
            state_d = LOCK;
            owner_d = sel_s;
        end else if (state_q == LOCK) begin
            state_d     = ARB;
            rr_ptr_d    = idx_inc(owner_q);
            burst_cnt_d = {BC_W{1'b0}};
        end else begin
            state_d = ARB;
        end
    end

    // Arbiter state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            rr_ptr_q    <= {IDX_W{1'b0}};
            owner_q     <= {IDX_W{1'b0}};
            burst_cnt_q <= {BC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    // Saturating per-requester accepted-beat counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready_o[i] && req_valid_i[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end else begin
                    cnt_q[i] <= cnt_q[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule
